io_channel_unit: RTL

Peripheral I/O channel bank directly downstream of the core's writeback stage and upstream of its decode-stage I/O read port. It holds sixteen 15-bit I/O channel registers addressed by the core's 4-bit channel select. It buffers keypad codes in a small FIFO exposed on the keyboard channel, and drives the display channel to an external DSKY driver through a valid/ready handshake.

---
 rtl/io_channel_unit.sv | 82 ++++++++
 1 files changed

// File: rtl/io_channel_unit.sv
// io_channel_unit: sixteen 15-bit I/O channels with a keypad FIFO channel and a display handshake channel
// Ports:
//   clock, rst_l                 core clock, asynchronous active-low reset
//   IO_read_sel / IO_read_data   combinational channel read (write bypass except on KEY_CHANNEL)
//   IO_write_sel/_data/_en       channel write from writeback
//   key_valid, key_code          keypad push side; key_ready = not full
//   key_pending                  FIFO non-empty interrupt request
//   dsp_valid, dsp_data          display word to the DSKY driver
//   dsp_ready                    display driver accepts the word
//   io_busy                      display buffer occupied
//   dsp_overflow                 sticky flag for a dropped DSP_CHANNEL write
module io_channel_unit #(
    parameter int         KEY_FIFO_DEPTH = 4,
    parameter logic [3:0] KEY_CHANNEL    = 4'o15,
    parameter logic [3:0] DSP_CHANNEL    = 4'o10
) (
    input  logic        clock,
    input  logic        rst_l,
    input  logic [3:0]  IO_read_sel,
    output logic [14:0] IO_read_data,
    input  logic [3:0]  IO_write_sel,
    input  logic [14:0] IO_write_data,
    input  logic        IO_write_en,
    input  logic        key_valid,
    input  logic [4:0]  key_code,
    output logic        key_ready,
    output logic        key_pending,
    output logic        dsp_valid,
    output logic [14:0] dsp_data,
    input  logic        dsp_ready,
    output logic        io_busy,
    output logic        dsp_overflow
);
    localparam int AW = $clog2(KEY_FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = KEY_FIFO_DEPTH[AW:0];
    logic [14:0]   regs [16];
    logic [4:0]    fifo [KEY_FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, empty, push, pop, dsp_wr, dsp_accept;
    assign full       = count == FULL_CNT;
    assign empty      = count == '0;
    assign push       = key_valid && !full;
    // a pop on an empty FIFO is dropped, so an empty FIFO with push+pop just pushes
    assign pop        = IO_write_en && IO_write_sel == KEY_CHANNEL && !empty;
    assign dsp_wr     = IO_write_en && IO_write_sel == DSP_CHANNEL;
    assign dsp_accept = dsp_wr && (!dsp_valid || dsp_ready);
    assign key_ready   = !full;
    assign key_pending = !empty;
    assign io_busy     = dsp_valid;
    // the keypad channel always shows the FIFO head and never the write bypass
    assign IO_read_data = IO_read_sel == KEY_CHANNEL ? (empty ? 15'd0 : {10'd0, fifo[rd_ptr]}) :
                          (IO_write_en && IO_write_sel == IO_read_sel) ? IO_write_data :
                          regs[IO_read_sel];
    always_ff @(posedge clock or negedge rst_l) begin
        if (!rst_l) begin
            for (int i = 0; i < 16; i++) regs[i] <= '0;
            for (int i = 0; i < KEY_FIFO_DEPTH; i++) fifo[i] <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            dsp_valid    <= 1'b0;
            dsp_data     <= '0;
            dsp_overflow <= 1'b0;
        end else begin
            if (IO_write_en && IO_write_sel != KEY_CHANNEL && IO_write_sel != DSP_CHANNEL)
                regs[IO_write_sel] <= IO_write_data;
            if (dsp_accept) begin
                regs[DSP_CHANNEL] <= IO_write_data;
                dsp_data          <= IO_write_data;
            end
            dsp_valid <= dsp_accept || (dsp_valid && !dsp_ready);
            if (dsp_wr && !dsp_accept) dsp_overflow <= 1'b1;
            if (push) begin
                fifo[wr_ptr] <= key_code;
                wr_ptr       <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end
endmodule
